rv_mem_pipe: RTL and testbench
==============================

# rv_mem_pipe

Parametrised successor to the single-cycle byte-enable data memory. It adds:
- configurable data width, depth and read latency;
- a valid/ready request and response handshake with backpressure;
- store lane alignment and load sign/zero extension done inside the block;
- misaligned and out-of-range fault reporting.

It sits behind the core's load/store unit as the data memory and returns exactly one response per accepted request, in order.

## Interface
- DATA_W, 32, data width in bits; 32 or 64 only.
- DEPTH_WORDS, 256, number of DATA_W-bit words.
- RD_LATENCY, 1, cycles from request accept to earliest response; range 1..4.
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  DATA_W  store data, LSB-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  load result, extended to DATA_W; 0 for stores and faults.
- rsp_err  out  1  request faulted.

## Operation
- A request is accepted on a cycle where req_valid && req_ready.
- Lane and word selection:
  - BYTES = DATA_W/8.
  - lane = req_addr mod BYTES.
  - word index = req_addr / BYTES.
- Fault conditions; any one faults the request:
  - lane not a multiple of (1<<req_size);
  - req_size=3 with DATA_W=32;
  - word index >= DEPTH_WORDS.
- A faulted request does not access the array. It still gets a response with rsp_err=1 and rsp_rdata=0.
- Store path: req_wdata is shifted left by lane*8. byte_en has (1<<req_size) ones starting at bit lane. Only the enabled bytes are written at the accept edge.
- Load path:
  - the array word is read at the accept edge;
  - it passes through RD_LATENCY-1 pipeline stages;
  - it is shifted right by lane*8 and masked to the access size;
  - it is then sign- or zero-extended to DATA_W.
  - A load of the full DATA_W ignores req_unsigned.
- Store responses: rsp_err=0, rsp_rdata=0.
- Responses are strictly in request order and enter a response FIFO of depth RD_LATENCY+1.
  - rsp_valid = FIFO not empty; the FIFO is fall-through.
  - The head is popped on rsp_valid && rsp_ready.
- Credit rule: req_ready = !rst && (inflight + fifo_count) < RD_LATENCY+1.
  - inflight counts accepted requests still in the pipeline.
  - req_ready does not depend combinationally on rsp_ready or req_valid.
- Ordering: a load accepted the cycle after a store to the same bytes returns the new data. There is never more than one access per cycle, so no read/write collision exists.

## Timing
- Request accepted at edge t → response enters the FIFO at t+RD_LATENCY−1 and rsp_valid is high in cycle t+RD_LATENCY. This holds when the FIFO is empty.
- With rsp_ready held at 1, one request is accepted every cycle with no bubbles, for any RD_LATENCY.
- Backpressure: while rsp_ready=0, the FIFO fills. req_ready falls once inflight+count reaches RD_LATENCY+1, and rises the cycle after a pop.
- While rsp_valid=1 and rsp_ready=0, rsp_rdata and rsp_err hold stable.
- Full FIFO with a simultaneous pop and a pipeline write: both occur and the count is unchanged. The credit rule guarantees no overflow.
- Reset values: req_ready=0 while rst=1 and 1 the first cycle after. rsp_valid=0, rsp_rdata=0, rsp_err=0. inflight=0, FIFO pointers and count = 0. Pipeline valid bits = 0.
- Reset mid-operation: in-flight and queued responses are dropped. Array contents are not reset; stores accepted before the reset edge stay committed.

## Structure
- Package rv_mem_pkg:
  - size enum MEM_B/MEM_H/MEM_W/MEM_D;
  - a response struct {rdata, err};
  - a function that builds byte_en from size and lane.
- Sub-module rv_mem_array:
  - parameters DATA_W and DEPTH_WORDS;
  - ports clk, wr_en, addr (word index), wr_data, byte_en, rd_data;
  - synchronous byte-enable write and registered read;
  - built with the DFF macros, no reset.
- The top level holds the fault check, lane logic, latency pipeline, response FIFO and credit counter.

## Test plan
- Store and load word: DATA_W=32, RD_LATENCY=1. SW 0xDEADBEEF @0x10, then LB @0x13 signed → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD.
- Partial store: SB 0x5A @0x11 over 0xDEADBEEF @0x10, then LW @0x10 → 0xDEAD5AEF. A load in the cycle immediately after the store sees the new byte.
- Faults:
  - LW @0x02 → rsp_err=1, rdata=0, memory unchanged;
  - SW @0x400 with DEPTH_WORDS=256 → rsp_err=1;
  - size=3 with DATA_W=32 → rsp_err=1.
- Backpressure: RD_LATENCY=3, rsp_ready=0, issue 6 loads. Exactly 4 are accepted and req_ready falls. Release rsp_ready → 4 in-order responses, then the remaining 2 are accepted.
- Throughput: RD_LATENCY=2, rsp_ready=1, 20 back-to-back loads → 20 accepts in 20 cycles, first response at cycle 2, in order.
- Mid-operation reset: assert rst with 3 outstanding loads → rsp_valid=0 next cycle and no stale response afterwards. A store accepted before reset reads back correctly.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared types for the pipelined data memory: access size, response word, pipeline metadata.
package rv_mem_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    typedef struct packed {
        logic [MAX_W-1:0] rdata;
        logic             err;
    } rsp_t;

    typedef struct packed {
        logic      vld;
        logic      we;
        logic      err;
        logic      uns;
        mem_size_e size;
        logic [2:0] lane;
    } meta_t;

    // (1 << size) enabled bytes starting at the lane
    function automatic logic [7:0] byte_en_f(input mem_size_e size, input logic [2:0] lane);
        logic [7:0] ones;
        ones = 8'((16'd1 << (4'd1 << size)) - 16'd1);
        return ones << lane;
    endfunction

endpackage

// File: rtl/rv_mem_pipe_if.sv
// Request/response handshake bundle between the load/store unit (master) and the data memory (slave).
interface rv_mem_pipe_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/rv_mem_array.sv
// Word-addressed storage with byte-enable write and registered read.
// Latency: read data valid the cycle after the address is presented.
// Backpressure: none; the caller issues at most one access per cycle.
module rv_mem_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic [DATA_W/8-1:0]            byte_en,
    output logic [DATA_W-1:0]              rd_data
);
    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byte_en[b]) mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        rd_data <= mem[addr];
    end
endmodule

// File: rtl/rv_mem_pipe.sv
// Pipelined byte-addressed data memory with alignment faults and load extension.
// Latency: RD_LATENCY cycles from accept to response when the response FIFO is empty.
// Backpressure: credit-based; req_ready drops once pipeline + FIFO hold RD_LATENCY+1 entries.
module rv_mem_pipe #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int RD_LATENCY  = 1
) (
    input  logic          clk,
    input  logic          rst,
    rv_mem_pipe_if.slave  bus
);
    import rv_mem_pkg::*;

    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int AW     = $clog2(DEPTH_WORDS);
    localparam int FD     = RD_LATENCY + 1;
    localparam int PW     = $clog2(FD);
    localparam int CW     = $clog2(FD + 1);

    logic [2:0]        lane;
    logic [31:0]       word_idx;
    mem_size_e         size;
    logic [2:0]        align_mask;
    logic              fault, accept, wr_en;
    logic [BYTES-1:0]  be;
    logic [DATA_W-1:0] wdata_sh, arr_rd, word_out;
    meta_t             meta_in;

    always_comb begin
        lane       = 3'(bus.req_addr[LANE_W-1:0]);
        word_idx   = bus.req_addr >> LANE_W;
        size       = mem_size_e'(bus.req_size);
        align_mask = 3'((4'd1 << size) - 4'd1);
        fault      = (|(lane & align_mask)) || ((size == MEM_D) && (DATA_W == 32))
                     || (word_idx >= 32'(DEPTH_WORDS));
        accept     = bus.req_valid && bus.req_ready;
        wr_en      = accept && bus.req_we && !fault;
        be         = BYTES'(byte_en_f(size, lane));
        wdata_sh   = bus.req_wdata << {lane, 3'b000};
        meta_in      = '0;
        meta_in.vld  = accept;
        meta_in.we   = bus.req_we;
        meta_in.err  = fault;
        meta_in.uns  = bus.req_unsigned;
        meta_in.size = size;
        meta_in.lane = lane;
    end

    rv_mem_array #(.DATA_W(DATA_W), .DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .addr    (AW'(word_idx)),
        .wr_data (wdata_sh),
        .byte_en (be),
        .rd_data (arr_rd)
    );

    // Metadata travels alongside the array read register plus the extra data stages
    meta_t meta_q [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) meta_q[i] <= '0;
        end else begin
            meta_q[0] <= meta_in;
            for (int i = 1; i < RD_LATENCY; i++) meta_q[i] <= meta_q[i-1];
        end
    end

    if (RD_LATENCY > 1) begin : g_dpipe
        logic [DATA_W-1:0] dq [RD_LATENCY-1];
        always_ff @(posedge clk) begin
            dq[0] <= arr_rd;
            for (int i = 1; i < RD_LATENCY - 1; i++) dq[i] <= dq[i-1];
        end
        assign word_out = dq[RD_LATENCY-2];
    end else begin : g_nopipe
        assign word_out = arr_rd;
    end

    meta_t             mo;
    logic [DATA_W-1:0] sh, ext;
    rsp_t              pipe_rsp;
    logic              pipe_vld;

    always_comb begin
        mo  = meta_q[RD_LATENCY-1];
        sh  = word_out >> {mo.lane, 3'b000};
        ext = sh;
        unique case (mo.size)
            MEM_B:   ext = mo.uns ? DATA_W'(sh[7:0])  : DATA_W'($signed(sh[7:0]));
            MEM_H:   ext = mo.uns ? DATA_W'(sh[15:0]) : DATA_W'($signed(sh[15:0]));
            MEM_W:   ext = mo.uns ? DATA_W'(sh[31:0]) : DATA_W'($signed(sh[31:0]));
            default: ext = sh;
        endcase
        pipe_vld       = mo.vld;
        pipe_rsp.err   = mo.err;
        pipe_rsp.rdata = (mo.err || mo.we) ? '0 : MAX_W'(ext);
    end

    // Fall-through FIFO: every pipeline output is written; an empty FIFO presents it directly
    rsp_t           fifo_mem [FD];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           push, pop;
    rsp_t           head;
    int             inflight;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        push          = pipe_vld;
        head          = (count == '0) ? pipe_rsp : fifo_mem[rd_ptr];
        bus.rsp_valid = (count != '0) || pipe_vld;
        pop           = bus.rsp_valid && bus.rsp_ready;
        bus.rsp_rdata = bus.rsp_valid ? DATA_W'(head.rdata) : '0;
        bus.rsp_err   = bus.rsp_valid && head.err;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= pipe_rsp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        inflight = 0;
        for (int i = 0; i < RD_LATENCY; i++) inflight += int'(meta_q[i].vld);
        bus.req_ready = !rst && ((inflight + int'(count)) < FD);
    end
endmodule

// File: tb/tb_rv_mem_pipe.sv
// Randomized bench for rv_mem_pipe against a byte-level memory model and in-order response queue.
module tb_rv_mem_pipe;
    localparam int LAT   = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv_mem_pipe_if #(.DATA_W(DW)) bus ();

    rv_mem_pipe #(.DATA_W(DW), .DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mem_m [1024];
    int          tests = 0, fails = 0, cyc = 0, acc_cnt = 0, pops = 0;
    bit          exact_lat = 0, rand_rdy = 0, hold_vld = 0, bp_done = 0;
    logic [31:0] hold_rdata, last_rdata, last_exp;
    logic        hold_err, last_err, last_exp_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte-granular reference: fault rules, store bytes, assemble and extend loads
    function automatic exp_t model_apply(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                         input logic uns, input logic [31:0] wdata);
        exp_t        e;
        int          n;
        logic [31:0] v;
        bit          bad;
        n   = 1 << size;
        bad = ((int'(addr[1:0]) % n) != 0) || (size == 2'd3) || ((addr / 4) >= DEPTH);
        e.err   = bad;
        e.rdata = '0;
        e.acc   = cyc;
        if (!bad) begin
            if (we) begin
                for (int i = 0; i < n; i++) mem_m[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[int'(addr) + i];
                if (!uns && n < 4 && v[8*n-1])
                    for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                e.rdata = v;
            end
        end
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.rsp_ready = ($urandom_range(3) != 0);
        end
    end

    // Single compare process: responses vs queue, hold stability, accepts into the model
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            hold_vld = 0;
        end else begin
            if (hold_vld) begin
                check("rsp_hold_valid", bus.rsp_valid, 1);
                check("rsp_hold_rdata", bus.rsp_rdata, hold_rdata);
                check("rsp_hold_err", bus.rsp_err, hold_err);
            end
            if (bus.rsp_valid && q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=0x%0h, expected no response", bus.rsp_rdata);
            end else if (bus.rsp_valid && bus.rsp_ready) begin
                e = q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_err", bus.rsp_err, e.err);
                if (exact_lat) check("rsp_latency", cyc - e.acc, LAT);
                last_rdata   = bus.rsp_rdata;
                last_err     = bus.rsp_err;
                last_exp     = e.rdata;
                last_exp_err = e.err;
                pops++;
            end
            hold_vld   = bus.rsp_valid && !bus.rsp_ready;
            hold_rdata = bus.rsp_rdata;
            hold_err   = bus.rsp_err;
            if (bus.req_valid && bus.req_ready) begin
                q.push_back(model_apply(bus.req_we, bus.req_addr, bus.req_size, bus.req_unsigned, bus.req_wdata));
                acc_cnt++;
            end
        end
    end

    task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata);
        logic got;
        got = 1'b0;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = bus.req_ready;
            @(posedge clk);
            #1;
        end
        if (!got) check("accept_timeout", 0, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
    endtask

    task automatic wait_pops(input int target);
        int n;
        n = 0;
        while (pops < target && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (pops < target) check("pop_timeout", pops, target);
    endtask

    task automatic check_lit(input string name, input logic [31:0] rd, input logic er);
        check({name, "_dut_rdata"}, last_rdata, rd);
        check({name, "_dut_err"}, last_err, er);
        check({name, "_model_rdata"}, last_exp, rd);
        check({name, "_model_err"}, last_exp_err, er);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p, a0, c0;
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;

        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_size = '0;
        bus.req_unsigned = 0; bus.req_wdata = '0; bus.rsp_ready = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", bus.req_ready, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_rdata", bus.rsp_rdata, 0);
        check("reset_rsp_err", bus.rsp_err, 0);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("post_reset_req_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) send(1, 32'(i * 4), 2, 0, $urandom);
        drain();

        p = pops;
        send(1, 32'h10, 2, 0, 32'hDEADBEEF);
        send(0, 32'h13, 0, 0, 0);
        wait_pops(p + 2);
        check_lit("lb_signed", 32'hFFFFFFDE, 0);
        send(0, 32'h13, 0, 1, 0);
        wait_pops(p + 3);
        check_lit("lbu", 32'h000000DE, 0);
        send(0, 32'h12, 1, 0, 0);
        wait_pops(p + 4);
        check_lit("lh_signed", 32'hFFFFDEAD, 0);

        p = pops;
        send(1, 32'h11, 0, 0, 32'hA5A5A55A);
        send(0, 32'h10, 2, 0, 0);
        wait_pops(p + 2);
        check_lit("sb_then_lw", 32'hDEAD5AEF, 0);

        p = pops;
        send(1, 32'h02, 2, 0, 32'h11111111);
        wait_pops(p + 1);
        check_lit("sw_misaligned", 0, 1);
        send(0, 32'h00, 2, 0, 0);
        send(0, 32'h02, 2, 0, 0);
        wait_pops(p + 3);
        check_lit("lw_misaligned", 0, 1);
        send(1, 32'h400, 2, 0, 32'h22222222);
        wait_pops(p + 4);
        check_lit("sw_out_of_range", 0, 1);
        send(0, 32'h10, 3, 0, 0);
        wait_pops(p + 5);
        check_lit("dword_on_32", 0, 1);
        drain();

        // Backpressure: credits cap outstanding requests at LAT+1
        bus.rsp_ready = 0;
        a0 = acc_cnt;
        p  = pops;
        bp_done = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(0, 32'(i * 4), 2, 0, 0);
                bp_done = 1;
            end
        join_none
        repeat (12) begin @(posedge clk); #1; end
        check("bp_accepts", acc_cnt - a0, LAT + 1);
        @(negedge clk);
        check("bp_ready_low", bus.req_ready, 0);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1;
        @(negedge clk);
        check("bp_ready_still_low", bus.req_ready, 0);
        @(negedge clk);
        check("bp_ready_rise", bus.req_ready, 1);
        for (int n = 0; n < 100 && !bp_done; n++) begin @(posedge clk); #1; end
        check("bp_sender_done", bp_done, 1);
        drain();
        check("bp_responses", pops - p, 6);

        // Throughput with the consumer always ready
        exact_lat = 1;
        a0 = acc_cnt;
        c0 = cyc;
        for (int i = 0; i < 20; i++) send(0, 32'($urandom_range(15) * 4), 2, 1'($urandom_range(1)), 0);
        check("tput_cycles", cyc - c0, 20);
        check("tput_accepts", acc_cnt - a0, 20);
        drain();
        exact_lat = 0;

        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(99);
            sz = 2'($urandom_range(2));
            a  = 32'($urandom_range(63)) & ~32'((1 << sz) - 1);
            if (r < 8) begin
                sz = 2;
                a  = a | 32'($urandom_range(3, 1));
            end else if (r < 12) begin
                a = 32'h400 + a;
            end else if (r < 14) begin
                sz = 3;
            end
            send(1'($urandom_range(1)), a, sz, 1'($urandom_range(1)), $urandom);
        end
        rand_rdy = 0;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1;
        drain();

        // Reset with outstanding work: queued responses vanish, committed store survives
        bus.rsp_ready = 0;
        send(1, 32'h20, 2, 0, 32'h12345678);
        send(0, 32'h00, 2, 0, 0);
        send(0, 32'h04, 2, 0, 0);
        send(0, 32'h08, 2, 0, 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_req_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;
        p = pops;
        bus.rsp_ready = 1;
        repeat (10) begin @(posedge clk); #1; end
        check("midrst_no_stale", pops - p, 0);
        send(0, 32'h20, 2, 0, 0);
        wait_pops(p + 1);
        check_lit("midrst_store_kept", 32'h12345678, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
